// File: rtl/core_mc_pkg.sv
// Shared types for the multi-cycle RV32 core: IR field types, ALU op encoding, config bundle.
package core_mc_pkg;

  typedef logic [6:0] opcode_t;
  typedef logic [2:0] funct3_t;
  typedef logic [6:0] funct7_t;

  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_SRL  = 4'd4,
    ALU_OP_SLTU = 4'd5
  } alu_op_t;

  typedef struct packed {
    logic [31:0] reset_pc;
  } config_t;

  localparam opcode_t OP_LUI    = 7'b0110111;
  localparam opcode_t OP_BRANCH = 7'b1100011;
  localparam opcode_t OP_IMM    = 7'b0010011;
  localparam opcode_t OP_REG    = 7'b0110011;

endpackage

// File: rtl/core_mc_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with halt, error traps
// and a retired-instruction counter.
module core_mc_sequencer
  import core_mc_pkg::*;
#(
  parameter config_t     CONF          = '0,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned INSTRET_W     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 imem_req_o,
  input  logic                 imem_ready_i,
  output logic                 ir_we_o,
  input  opcode_t              op_i,
  input  funct3_t              funct3_i,
  input  funct7_t              funct7_i,
  input  logic                 alu_zero_i,
  output logic                 pc_we_o,
  output logic                 pc_src_o,
  output logic                 reg_write_o,
  output logic                 alu_src_o,
  output logic                 wd_src_o,
  output alu_op_t              alu_op_o,
  input  logic                 halt_i,
  output logic                 halted_o,
  output logic                 illegal_o,
  output logic                 fetch_timeout_o,
  output logic                 retired_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam int unsigned TmoW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StReset, StFetch, StDecode, StExecute, StWriteback, StHalted, StError
  } state_e;

  typedef enum logic [1:0] {ClsAlu, ClsLui, ClsBeq, ClsBne} cls_e;

  state_e               state_q;
  cls_e                 cls_q;
  alu_op_t              alu_op_q;
  logic                 alu_src_q, wd_src_q;
  logic                 illegal_q, fetch_timeout_q;
  logic [TmoW-1:0]      tmo_q;
  logic [INSTRET_W-1:0] instret_q;

  logic    dec_ok, dec_asrc, dec_wsrc;
  cls_e    dec_cls;
  alu_op_t dec_aop;
  logic    is_branch, retire, in_alu;

  logic unused_conf;
  assign unused_conf = ^CONF;

  always_comb begin
    dec_ok   = 1'b1;
    dec_cls  = ClsAlu;
    dec_aop  = ALU_OP_ADD;
    dec_asrc = 1'b0;
    dec_wsrc = 1'b0;
    case (op_i)
      OP_LUI: begin
        dec_cls  = ClsLui;
        dec_wsrc = 1'b1;
      end
      OP_BRANCH: begin
        dec_aop = ALU_OP_SUB;
        case (funct3_i)
          3'b000:  dec_cls = ClsBeq;
          3'b001:  dec_cls = ClsBne;
          default: dec_ok  = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec_asrc = 1'b1;
        case (funct3_i)
          3'b000:  dec_aop = ALU_OP_ADD;
          3'b111:  dec_aop = ALU_OP_AND;
          default: dec_ok  = 1'b0;
        endcase
      end
      OP_REG: begin
        case ({funct7_i, funct3_i})
          {7'h00, 3'b000}: dec_aop = ALU_OP_ADD;
          {7'h20, 3'b000}: dec_aop = ALU_OP_SUB;
          {7'h00, 3'b111}: dec_aop = ALU_OP_AND;
          {7'h00, 3'b110}: dec_aop = ALU_OP_OR;
          {7'h00, 3'b101}: dec_aop = ALU_OP_SRL;
          {7'h00, 3'b011}: dec_aop = ALU_OP_SLTU;
          default:         dec_ok  = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
  always_comb begin
    is_branch       = (cls_q == ClsBeq) || (cls_q == ClsBne);
    retire          = ((state_q == StExecute) && is_branch) || (state_q == StWriteback);
    in_alu          = (state_q == StExecute) || (state_q == StWriteback);
    imem_req_o      = (state_q == StFetch);
    ir_we_o         = (state_q == StFetch) && imem_ready_i;
    pc_we_o         = retire;
    pc_src_o        = (state_q == StExecute) &&
                      (((cls_q == ClsBeq) && alu_zero_i) || ((cls_q == ClsBne) && !alu_zero_i));
    reg_write_o     = (state_q == StWriteback);
    alu_src_o       = in_alu && alu_src_q;
    wd_src_o        = (state_q == StWriteback) && wd_src_q;
    alu_op_o        = in_alu ? alu_op_q : ALU_OP_ADD;
    halted_o        = (state_q == StHalted);
    retired_o       = retire;
    illegal_o       = illegal_q;
    fetch_timeout_o = fetch_timeout_q;
    instret_o       = instret_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StReset;
      cls_q           <= ClsAlu;
      alu_op_q        <= ALU_OP_ADD;
      alu_src_q       <= 1'b0;
      wd_src_q        <= 1'b0;
      illegal_q       <= 1'b0;
      fetch_timeout_q <= 1'b0;
      tmo_q           <= '0;
      instret_q       <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
      unique case (state_q)
        StReset: state_q <= halt_i ? StHalted : StFetch;
        StFetch: begin
          if (imem_ready_i) begin
            state_q <= StDecode;
            tmo_q   <= '0;
          end else if (tmo_q == TmoW'(FETCH_TIMEOUT - 1)) begin
            state_q         <= StError;
            fetch_timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDecode: begin
          if (dec_ok) begin
            state_q   <= StExecute;
            cls_q     <= dec_cls;
            alu_op_q  <= dec_aop;
            alu_src_q <= dec_asrc;
            wd_src_q  <= dec_wsrc;
          end else begin
            state_q   <= StError;
            illegal_q <= 1'b1;
          end
        end
        StExecute: begin
          if (is_branch) state_q <= halt_i ? StHalted : StFetch;
          else           state_q <= StWriteback;
        end
        StWriteback: state_q <= halt_i ? StHalted : StFetch;
        StHalted:    if (!halt_i) state_q <= StFetch;
        StError:     state_q <= StError;
        default:     state_q <= StError;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mc_sequencer.sv
// Randomized self-checking bench for core_mc_sequencer against an instruction-level model.
module tb_core_mc_sequencer;
  import core_mc_pkg::*;

  localparam int FT = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_ready = 1'b0;
  logic          alu_zero = 1'b0;
  logic          halt = 1'b0;
  opcode_t       op = '0;
  funct3_t       funct3 = '0;
  funct7_t       funct7 = '0;
  logic          imem_req, ir_we, pc_we, pc_src, reg_write, alu_src, wd_src;
  logic          halted, illegal, fetch_timeout, retired;
  alu_op_t       alu_op;
  logic [IW-1:0] instret;
  logic [10:0]   outs;

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  core_mc_sequencer #(.FETCH_TIMEOUT(FT), .INSTRET_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .imem_req_o(imem_req), .imem_ready_i(imem_ready),
    .ir_we_o(ir_we), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .alu_zero_i(alu_zero), .pc_we_o(pc_we), .pc_src_o(pc_src), .reg_write_o(reg_write),
    .alu_src_o(alu_src), .wd_src_o(wd_src), .alu_op_o(alu_op), .halt_i(halt),
    .halted_o(halted), .illegal_o(illegal), .fetch_timeout_o(fetch_timeout),
    .retired_o(retired), .instret_o(instret)
  );

  always #5 clk = ~clk;

  assign outs = {imem_req, ir_we, pc_we, pc_src, reg_write, alu_src, wd_src,
                 halted, retired, illegal, fetch_timeout};

  function automatic logic [10:0] o(input bit req, ir, pcwe, pcsrc, rw, asrc, wsrc,
                                    hl, ret, ill, tmo);
    return {req, ir, pcwe, pcsrc, rw, asrc, wsrc, hl, ret, ill, tmo};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic exp_outs(input string tag, input logic [10:0] e, input alu_op_t eop);
    #1;
    chk_eq(tag, 32'(outs), 32'(e));
    chk_eq({tag, "_aop"}, 32'(alu_op), 32'(eop));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ISA table of the supported subset. kind: 0 ALU, 1 LUI, 2 BEQ, 3 BNE.
  task automatic ref_dec(input logic [6:0] iop, input logic [2:0] f3, input logic [6:0] f7,
                         output bit ok, output int kind, output alu_op_t aop,
                         output bit asrc, output bit wsrc);
    ok = 0; kind = 0; aop = ALU_OP_ADD; asrc = 0; wsrc = 0;
    if (iop == 7'h37) begin
      ok = 1; kind = 1; wsrc = 1;
    end else if (iop == 7'h63 && f3 <= 3'd1) begin
      ok = 1; kind = 2 + int'(f3); aop = ALU_OP_SUB;
    end else if (iop == 7'h13 && (f3 == 3'd0 || f3 == 3'd7)) begin
      ok = 1; asrc = 1; aop = (f3 == 3'd7) ? ALU_OP_AND : ALU_OP_ADD;
    end else if (iop == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      ok = 1; aop = ALU_OP_SUB;
    end else if (iop == 7'h33 && f7 == 7'h00) begin
      ok = 1;
      case (f3)
        3'd0: aop = ALU_OP_ADD;
        3'd7: aop = ALU_OP_AND;
        3'd6: aop = ALU_OP_OR;
        3'd5: aop = ALU_OP_SRL;
        3'd3: aop = ALU_OP_SLTU;
        default: ok = 0;
      endcase
    end
  endtask

  task automatic do_reset(input bit h);
    rst = 1'b1; imem_ready = 1'b0; halt = h;
    exp_outs("rst_async", '0, ALU_OP_ADD);
    @(posedge clk);
    @(posedge clk);
    #2;
    exp_outs("rst_hold", '0, ALU_OP_ADD);
    chk_eq("rst_instret", 32'(instret), 32'd0);
    rst = 1'b0;
    exp_instret = 0;
    exp_outs("reset_state", '0, ALU_OP_ADD);
    if (h) begin
      cyc();
      exp_outs("rst_halted", o(0,0,0,0,0,0,0,1,0,0,0), ALU_OP_ADD);
      halt = 1'b0;
      exp_outs("rst_halted_rel", o(0,0,0,0,0,0,0,1,0,0,0), ALU_OP_ADD);
    end
  endtask

  task automatic error_hold(input logic [10:0] flags);
    for (int i = 0; i < 3; i++) begin
      cyc();
      halt = 1'($urandom);
      imem_ready = 1'($urandom);
      exp_outs("error_state", flags, ALU_OP_ADD);
    end
    imem_ready = 1'b0;
    do_reset(0);
  endtask

  task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic [6:0] if7,
                           input int wait_n, input bit zero, input bit hlt, input int hold,
                           input bit rst_wb);
    bit ok, asrc, wsrc, br, take;
    int kind;
    alu_op_t aop;
    ref_dec(iop, if3, if7, ok, kind, aop, asrc, wsrc);
    br   = (kind >= 2);
    take = (kind == 2 && zero) || (kind == 3 && !zero);
    cyc();
    chk_eq("instret", 32'(instret), 32'(exp_instret));
    for (int w = 0; w <= FT; w++) begin
      if (w > 0) cyc();
      halt = 1'($urandom);
      imem_ready = (w == wait_n);
      op = iop; funct3 = if3; funct7 = if7;
      exp_outs("fetch", o(1, w == wait_n, 0,0,0,0,0,0,0,0,0), ALU_OP_ADD);
      if (w == wait_n) break;
      if (w == FT - 1) begin
        cyc();
        imem_ready = 1'b0;
        exp_outs("timeout", o(0,0,0,0,0,0,0,0,0,0,1), ALU_OP_ADD);
        error_hold(o(0,0,0,0,0,0,0,0,0,0,1));
        return;
      end
    end
    cyc();
    imem_ready = 1'b0;
    halt = 1'($urandom);
    exp_outs("decode", '0, ALU_OP_ADD);
    if (!ok) begin
      cyc();
      exp_outs("illegal", o(0,0,0,0,0,0,0,0,0,1,0), ALU_OP_ADD);
      error_hold(o(0,0,0,0,0,0,0,0,0,1,0));
      return;
    end
    cyc();
    alu_zero = zero;
    halt = hlt;
    exp_outs("execute", o(0,0,br,take,0,asrc,0,0,br,0,0), aop);
    if (!br) begin
      cyc();
      alu_zero = 1'($urandom);
      exp_outs("writeback", o(0,0,1,0,1,asrc,wsrc,0,1,0,0), aop);
      if (rst_wb) begin
        do_reset(0);
        return;
      end
    end
    exp_instret = (exp_instret + 1) % (1 << IW);
    if (hlt) begin
      for (int h = 0; h <= hold; h++) begin
        cyc();
        halt = (h < hold);
        exp_outs("halted", o(0,0,0,0,0,0,0,1,0,0,0), ALU_OP_ADD);
      end
    end
  endtask

  task automatic gen_legal(output logic [6:0] iop, output logic [2:0] f3, output logic [6:0] f7);
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    case ($urandom_range(0, 10))
      0: iop = 7'h37;
      1: begin iop = 7'h63; f3 = 3'd0; end
      2: begin iop = 7'h63; f3 = 3'd1; end
      3: begin iop = 7'h13; f3 = 3'd0; end
      4: begin iop = 7'h13; f3 = 3'd7; end
      5: begin iop = 7'h33; f3 = 3'd0; f7 = 7'h00; end
      6: begin iop = 7'h33; f3 = 3'd0; f7 = 7'h20; end
      7: begin iop = 7'h33; f3 = 3'd7; f7 = 7'h00; end
      8: begin iop = 7'h33; f3 = 3'd6; f7 = 7'h00; end
      9: begin iop = 7'h33; f3 = 3'd5; f7 = 7'h00; end
      default: begin iop = 7'h33; f3 = 3'd3; f7 = 7'h00; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] rop, rf7;
    logic [2:0] rf3;
    do_reset(0);
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr(7'h63, 3'd0, 7'h00, 0, 1, 0, 0, 0);
    run_instr(7'h63, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run_instr(7'h63, 3'd1, 7'h00, 0, 1, 0, 0, 0);
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 0, 0, 0);
    run_instr(7'h37, 3'd5, 7'h12, 1, 0, 0, 0, 0);
    run_instr(7'h13, 3'd0, 7'h55, 2, 0, 0, 0, 0);
    run_instr(7'h33, 3'd0, 7'h00, 3, 0, 0, 0, 0);
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 1, 2, 0);
    run_instr(7'h63, 3'd0, 7'h00, 0, 1, 1, 0, 0);
    run_instr(7'h33, 3'd0, 7'h00, 9, 0, 0, 0, 0);
    run_instr(7'h33, 3'd0, 7'h01, 0, 0, 0, 0, 0);
    do_reset(1);
    run_instr(7'h33, 3'd7, 7'h00, 0, 0, 0, 0, 0);
    run_instr(7'h33, 3'd0, 7'h20, 0, 0, 0, 0, 1);

    for (int i = 0; i < 17; i++) begin
      gen_legal(rop, rf3, rf7);
      run_instr(rop, rf3, rf7, $urandom_range(0, FT - 1), 1'($urandom),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 0);
    end
    cyc();
    chk_eq("instret_wrap", 32'(instret), 32'd1);
    do_reset(0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        gen_legal(rop, rf3, rf7);
      end else begin
        rop = ($urandom_range(0, 1) == 1) ? 7'h33 : 7'($urandom);
        rf3 = 3'($urandom);
        rf7 = 7'($urandom);
      end
      run_instr(rop, rf3, rf7, $urandom_range(0, FT + 1), 1'($urandom),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                ($urandom_range(0, 14) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
